// File: rtl/alu593_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu593_pkg                                              |
// | Desc     : ALU593 opcode encoding and arbiter state constants.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package alu593_pkg;

    typedef enum logic [3:0] {
        no_op    = 4'b0000,
        add_op   = 4'b0001,
        and_op   = 4'b0010,
        xor_op   = 4'b0011,
        mul_op   = 4'b0100,
        sp_func1 = 4'b0101,
        sp_func2 = 4'b0110,
        sp_func3 = 4'b0111,
        load     = 4'b1000,
        store    = 4'b1001,
        rsvd1    = 4'b1010,
        rsvd2    = 4'b1011,
        rsvd3    = 4'b1100,
        rsvd4    = 4'b1101,
        rsvd5    = 4'b1110,
        no_op1   = 4'b1111
    } operation_t;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t c_st_idle  = 3'd0;
    localparam arb_state_t c_st_issue = 3'd1;
    localparam arb_state_t c_st_wait  = 3'd2;
    localparam arb_state_t c_st_resp  = 3'd3;
    localparam arb_state_t c_st_abort = 3'd4;

    function automatic logic is_reserved(input operation_t op);
        return (op >= rsvd1) && (op <= rsvd5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rr_arbiter                                              |
// | Desc     : Combinational round-robin picker, search starts at ptr. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   w_cand;
    logic w_found;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < N; i++) begin
            w_cand = (int'(ptr) + i) % N;
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                grant[w_cand]  = 1'b1;
                idx            = IW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu593_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu593_arbiter                                          |
// | Desc     : Round-robin sharing of one ALU593 with timeout recovery.|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module alu593_arbiter
    import alu593_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       rsp_result,
    output logic              rsp_err,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_start,
    output logic              alu_reset_n,
    input  logic              alu_done,
    input  logic [15:0]       alu_result,
    output logic              busy
);

    localparam int c_iw = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_cw = $clog2(TIMEOUT);
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(TIMEOUT - 1);

    arb_state_t        r_state;
    logic [c_iw-1:0]   r_ptr;
    logic [c_iw-1:0]   r_gidx;
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [3:0]        r_op;
    logic [c_cw-1:0]   r_cnt;
    logic [15:0]       r_result;
    logic              r_err;

    logic [NREQ-1:0]   w_grant;
    logic [c_iw-1:0]   w_idx;
    logic [7:0]        w_sel_a;
    logic [7:0]        w_sel_b;
    operation_t        w_sel_op;
    logic [c_iw-1:0]   w_next_ptr;
    logic [NREQ-1:0]   w_onehot;
    logic              w_active;
    logic              w_in_resp;

    rr_arbiter #(
        .N  (NREQ),
        .IW (c_iw)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_sel_a    = req_a[{w_idx, 3'b000} +: 8];
    assign w_sel_b    = req_b[{w_idx, 3'b000} +: 8];
    assign w_sel_op   = operation_t'(req_op[{w_idx, 2'b00} +: 4]);
    assign w_next_ptr = (r_gidx == c_iw'(NREQ - 1)) ? '0 : r_gidx + c_iw'(1);
    assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;

    // Every output is forced quiet while reset is held, regardless of state.
    assign w_active    = ~reset;
    assign w_in_resp   = w_active && (r_state == c_st_resp);
    assign req_ready   = (w_active && r_state == c_st_idle) ? w_grant : '0;
    assign rsp_valid   = w_in_resp ? w_onehot : '0;
    assign rsp_result  = w_in_resp ? r_result : '0;
    assign rsp_err     = w_in_resp && r_err;
    assign alu_start   = w_active && (r_state == c_st_issue || r_state == c_st_wait);
    assign alu_a       = w_active ? r_a  : '0;
    assign alu_b       = w_active ? r_b  : '0;
    assign alu_op      = w_active ? r_op : '0;
    assign alu_reset_n = w_active && (r_state != c_st_abort);
    assign busy        = w_active && (r_state != c_st_idle);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|req_valid) begin
                        r_gidx <= w_idx;
                        r_a    <= w_sel_a;
                        r_b    <= w_sel_b;
                        r_op   <= w_sel_op;
                        if (is_reserved(w_sel_op)) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                            r_state  <= c_st_resp;
                        end else begin
                            r_state  <= c_st_issue;
                        end
                    end
                end
                c_st_issue: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    // done takes priority over the final timeout cycle
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_err    <= 1'b0;
                        r_state  <= c_st_resp;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state  <= c_st_abort;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                c_st_abort: begin
                    r_err    <= 1'b1;
                    r_result <= '0;
                    r_state  <= c_st_resp;
                end
                c_st_resp: begin
                    r_ptr   <= w_next_ptr;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu593_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_alu593_arbiter                                       |
// | Desc     : Scoreboard bench with behavioural ALU and arbiter model.|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_alu593_arbiter;
    import alu593_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_result;
    logic              rsp_err;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_op;
    logic              alu_start;
    logic              alu_reset_n;
    logic              alu_done;
    logic [15:0]       alu_result;
    logic              busy;

    alu593_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_reset_n (alu_reset_n),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .busy        (busy)
    );

    typedef struct {
        int          g;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [15:0] res;
        logic        err;
        logic        tmo;
        logic        rsvd;
        int          rcyc;
    } txn_t;

    txn_t sb[$];
    int   alu_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    bit   stim_done = 1'b0;

    // requester-side state: pending flag, operands, ALU delay (0 = never done)
    bit         pend [NREQ];
    logic [7:0] pa   [NREQ];
    logic [7:0] pb   [NREQ];
    logic [3:0] pop  [NREQ];
    int         pk   [NREQ];
    bit         in_op;
    int         s_cnt;
    int         cur_k;

    initial begin
        clk = 1'b0;
        forever begin
            #5 clk = 1'b1;
            cyc = cyc + 1;
            #5 clk = 1'b0;
        end
    end

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        case (operation_t'(op))
            add_op:  return 16'(a) + 16'(b);
            and_op:  return {8'h00, a & b};
            xor_op:  return {8'h00, a ^ b};
            mul_op:  return 16'(a) * 16'(b);
            default: return {b, a};
        endcase
    endfunction

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return NREQ'(1) << ((p + i) % NREQ);
        return '0;
    endfunction

    task automatic load(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input int k);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pop[i]  = op;
        pk[i]   = k;
    endtask

    task automatic cycle();
        int   g;
        txn_t t;
        @(negedge clk);
        if (!reset && req_ready != '0) begin
            g = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
            t.g    = g;
            t.a    = pa[g];
            t.b    = pb[g];
            t.op   = pop[g];
            t.rsvd = (pop[g] >= 4'd10) && (pop[g] <= 4'd14);
            t.tmo  = !t.rsvd && (pk[g] == 0);
            t.err  = t.rsvd || t.tmo;
            t.res  = t.err ? 16'h0000 : alu_fn(pa[g], pb[g], pop[g]);
            t.rcyc = cyc + (t.rsvd ? 1 : (t.tmo ? TIMEOUT + 3 : pk[g] + 2));
            sb.push_back(t);
            if (!t.rsvd) alu_q.push_back(pk[g]);
            pend[g] = 1'b0;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            alu_q.delete();
            in_op = 1'b0;
        end
        // ALU model: s_cnt counts start-high cycles, first WAIT cycle is s_cnt==2
        if (alu_start) begin
            if (!in_op) begin
                in_op = 1'b1;
                s_cnt = 1;
                cur_k = (alu_q.size() != 0) ? alu_q.pop_front() : 0;
            end else begin
                s_cnt = s_cnt + 1;
            end
            alu_done   = (cur_k != 0) && (s_cnt == cur_k + 1);
            alu_result = alu_done ? alu_fn(alu_a, alu_b, alu_op) : 16'($urandom);
        end else begin
            in_op      = 1'b0;
            alu_done   = ($urandom_range(3) == 0);
            alu_result = 16'($urandom);
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*8 +: 8]    = pa[i];
            req_b[i*8 +: 8]    = pb[i];
            req_op[i*4 +: 4]   = pop[i];
        end
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input int bound);
        for (int n = 0; n < bound; n++) begin
            cycle();
            if (!any_pend() && sb.size() == 0 && !busy && req_valid == '0) break;
        end
    endtask

    // stimulus
    initial begin
        int r;
        int k;
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        in_op      = 1'b0;
        s_cnt      = 0;
        cur_k      = 0;
        for (int i = 0; i < NREQ; i++) load(i, 8'h00, 8'h00, 4'h0, 1);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        load(0, 8'hFF, 8'h01, add_op, 1);
        wait_idle(100);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        load(0, 8'h03, 8'h05, mul_op, 1);
        load(1, 8'h11, 8'h0F, mul_op, 2);
        load(2, 8'h10, 8'h10, mul_op, 3);
        load(3, 8'hFF, 8'hFF, mul_op, 1);
        wait_idle(100);

        load(1, 8'h12, 8'h34, 4'b1100, 1);
        wait_idle(100);

        load(2, 8'hAA, 8'h55, add_op, 0);
        load(3, 8'h21, 8'h43, xor_op, 2);
        wait_idle(300);

        load(0, 8'h07, 8'h09, and_op, TIMEOUT);
        wait_idle(300);

        load(1, 8'h5A, 8'hA5, add_op, 0);
        repeat (8) cycle();
        reset = 1'b1;
        load(1, 8'h5A, 8'hA5, add_op, 3);
        load(3, 8'h02, 8'h03, mul_op, 2);
        cycle();
        reset = 1'b0;
        wait_idle(100);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    r = int'($urandom_range(19));
                    k = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT - 1
                                                 : int'($urandom_range(6, 1));
                    load(i, 8'($urandom), 8'($urandom), 4'($urandom), k);
                end else if (pend[i] && $urandom_range(49) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            cycle();
        end
        wait_idle(1000);
        stim_done = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    initial begin
        bit              prev_rst;
        logic            prev_rstn;
        int              busy_run;
        int              ptr_m;
        logic [NREQ-1:0] exp_rdy;
        txn_t            t;
        prev_rst  = 1'b1;
        prev_rstn = 1'b0;
        busy_run  = 0;
        ptr_m     = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outputs",
                    32'({req_ready, rsp_valid, alu_start, busy, alu_reset_n, rsp_err}), 32'd0);
                sb.delete();
                ptr_m    = 0;
                busy_run = 0;
            end else begin
                if (prev_rst) chk("post_reset_idle", 32'({busy, rsp_valid, alu_start}), 32'd0);
                exp_rdy = busy ? '0 : rr_pick(req_valid, ptr_m);
                if (exp_rdy != '0 || req_ready != '0)
                    chk("grant", 32'(req_ready), 32'(exp_rdy));
                for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) ptr_m = (i + 1) % NREQ;
                if (alu_start) begin
                    if (sb.size() == 0 || sb[0].rsvd)
                        chk("alu_start_unexpected", 32'd1, 32'd0);
                    else
                        chk("alu_operands", 32'({alu_a, alu_b, alu_op}),
                            32'({sb[0].a, sb[0].b, sb[0].op}));
                end
                if (!alu_reset_n)
                    chk("alu_reset_pulse", 32'(sb.size() != 0 && sb[0].tmo), 32'd1);
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        t = sb.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(1) << t.g);
                        chk("rsp_result", 32'(rsp_result), 32'(t.res));
                        chk("rsp_err", 32'(rsp_err), 32'(t.err));
                        chk("rsp_cycle", 32'(cyc), 32'(t.rcyc));
                        chk("abort_pulse_before_rsp", 32'(prev_rstn), 32'(!t.tmo));
                    end
                end else if (sb.size() != 0 && cyc > sb[0].rcyc) begin
                    chk("rsp_missing", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
                busy_run = busy ? busy_run + 1 : 0;
                if (busy_run > TIMEOUT + 8) begin
                    chk("busy_stuck", 32'(busy_run), 32'd0);
                    busy_run = 0;
                end
            end
            prev_rst  = reset;
            prev_rstn = alu_reset_n;
            if (cyc > 80000) begin
                chk("watchdog", 32'(cyc), 32'd0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
            if (stim_done) begin
                chk("scoreboard_drained", 32'(sb.size()), 32'd0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu593_arbiter.md
Name: alu593_arbiter

Overview:
- Shares one ALU593 instance between NREQ independent requesters.
- Round-robin selection; one operation in flight at a time.
- Drives the ALU start/done handshake, captures the result, and returns it to the winning requester with a one-cycle response pulse.
- Rejects reserved opcodes locally and recovers from a hung ALU by timeout, so a requester is never left waiting.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles to wait for ALU done before aborting (>= 2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request, held until accepted.
- req_a  in  NREQ*8  packed operand A, requester i at [8i+7:8i].
- req_b  in  NREQ*8  packed operand B.
- req_op  in  NREQ*4  packed opcode (operation_t encoding).
- req_ready  out  NREQ  one-hot accept pulse, one cycle.
- rsp_valid  out  NREQ  one-hot response pulse, one cycle.
- rsp_result  out  16  result, valid with rsp_valid.
- rsp_err  out  1  1 = reserved opcode or timeout, valid with rsp_valid.
- alu_a  out  8  to ALU593 A.
- alu_b  out  8  to ALU593 B.
- alu_op  out  4  to ALU593 op.
- alu_start  out  1  to ALU593 start.
- alu_reset_n  out  1  to ALU593 reset_n; equals ~reset, and is also forced low for one cycle after a timeout.
- alu_done  in  1  from ALU593 done.
- alu_result  in  16  from ALU593 result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, priority pointer=0, all outputs 0 except alu_reset_n=0 while reset is high.
- Reset mid-operation aborts immediately. No response is issued and alu_start drops on the next edge.
- States: IDLE, ISSUE, WAIT, RESP, ABORT.
- IDLE:
  - If any req_valid is high, the round-robin arbiter picks winner g, starting its search at the pointer.
  - req_ready[g]=1 in that same cycle (combinational accept).
  - A/B/op of g are registered.
  - If op is rsvd1..rsvd5 (4'b1010..4'b1110): go to RESP with err=1, result=16'h0000; the ALU is not touched.
  - Otherwise go to ISSUE.
- ISSUE: alu_start=1, alu_a/b/op driven from the registered values. Timeout counter cleared. Go to WAIT.
- WAIT:
  - alu_start stays 1 and operands stay stable.
  - If alu_done=1: capture alu_result, alu_start=0 from the next cycle, go to RESP with err=0.
  - Else the counter increments. When the counter reaches TIMEOUT-1 without done, go to ABORT.
- ABORT: alu_start=0 and alu_reset_n=0 for one cycle. Load err=1, result=16'h0000. Go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle, with rsp_result and rsp_err.
  - Pointer becomes (g+1) mod NREQ.
  - Go to IDLE.
- no_op/no_op1 (4'b0000/4'b1111) go through the ALU normally; the arbiter does not special-case them.
- req_ready is never asserted outside IDLE. New requests wait while busy.
- Latency with an ALU done on the k-th WAIT cycle: accept cycle 0, start asserted cycle 1, rsp_valid at cycle k+2.
- Reserved-op latency: rsp_valid at cycle 1.
- Fairness: each requester holding req_valid continuously is served within NREQ grants.
- alu_done high in IDLE or RESP is ignored.
- alu_done arriving in the same cycle the counter hits TIMEOUT-1: done wins and the response is normal.
- A requester dropping req_valid before it is accepted is legal; it is simply not granted.

Decomposition:
- alu593_pkg holds:
  - operation_t, the 4-bit enum: no_op, add_op, and_op, xor_op, mul_op, sp_func1..3, load, store, rsvd1..5, no_op1.
  - Function is_reserved(operation_t).
  - Arbiter state enum.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index.
  - Purely combinational.
- The FSM, registers and timeout counter stay in alu593_arbiter.

Test Plan:
- Single request: req0 add_op A=8'hFF B=8'h01; ALU model asserts done after 1 WAIT cycle with 16'h0100 -> req_ready[0] at cycle 0, alu_start high cycles 1-2, rsp_valid[0] at cycle 3, result 16'h0100, err=0.
- All four requesters valid continuously with mul_op, pointer=0 -> grant order 0,1,2,3,0; each rsp_valid matches its own operands, e.g. req2 A=8'h10 B=8'h10 -> 16'h0100.
- Reserved op: req1 op=4'b1100 -> rsp_valid[1] one cycle after accept, err=1, result 16'h0000; alu_start never asserted.
- Timeout: ALU model never raises done, TIMEOUT=64 -> alu_start drops, alu_reset_n low for one cycle, rsp_err=1; the next queued request is then served normally.
- Done on the last timeout cycle: alu_done=1 exactly when the counter is 63 -> normal response, err=0, no ALU reset pulse.
- Reset asserted in WAIT -> the next cycle shows state IDLE, alu_start=0, no rsp_valid, pointer=0; the request still held is re-accepted after reset deasserts.
